sprite_anim_color: RTL and testbench

//  Parametrised animated-sprite pixel generator; successor to the fixed barrel colour block.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_rom.sv | 31 +++
 rtl/sprite_anim_color.sv | 187 ++++++++++++++++++
 tb/tb_sprite_anim_color.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the animated sprite pixel generator: colour key,
// mode encoding, sequencer state type and ROM address width helper.
package sprite_pkg;

  localparam logic [15:0] TRANSPARENT = 16'hFFFF;

  localparam logic MODE_ROLL = 1'b0;
  localparam logic MODE_FALL = 1'b1;

  typedef enum logic {
    ROLL = 1'b0,
    FALL = 1'b1
  } state_t;

  // Address width that covers the larger (fall) image.
  function automatic int addr_w(input int fall_w, input int spr_h);
    return $clog2(fall_w * spr_h);
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// One animation frame image with a registered (synchronous) read port.
// Contents are a generated pattern: key colour at every address whose low
// six bits are all ones, otherwise {SEED[3:0], 2'b00, addr[9:0]}, so each
// frame is distinguishable and carries a few transparent key pixels.
// Addresses at or beyond DEPTH read back as the key colour.
module sprite_rom #(
  parameter int DEPTH   = 1008,
  parameter int COLOR_W = 16,
  parameter int AW      = 10,
  parameter int SEED    = 1
) (
  input  logic               clk,
  input  logic [AW-1:0]      addr,
  output logic [COLOR_W-1:0] data
);

  function automatic logic [COLOR_W-1:0] rom_word(input logic [AW-1:0] a);
    logic [15:0] w;
    if ((int'(a) >= DEPTH) || (a[5:0] == 6'h3F)) begin
      return {COLOR_W{1'b1}};
    end
    w = {4'(SEED), 2'b00, 10'(a)};
    return COLOR_W'(w);
  endfunction

  // Registered read: data for the address presented on the previous edge.
  always_ff @(posedge clk) begin
    data <= rom_word(addr);
  end

endmodule

// File: rtl/sprite_anim_color.sv
// Animated sprite pixel generator: roll/fall sequencer with frame timer,
// hit test and address generation, per-frame ROM bank, two-stage pixel
// pipeline (ROM read + output register).
// Optional build macro SPRITE_HFLIP_EN adds a 'flip' input that mirrors
// the image horizontally; without it the image is always unmirrored.
module sprite_anim_color
  import sprite_pkg::*;
#(
  parameter int NUM_ROLL_FRAMES = 4,
  parameter int NUM_FALL_FRAMES = 2,
  parameter int ROLL_W          = 32,
  parameter int FALL_W          = 42,
  parameter int SPR_H           = 24,
  parameter int FRAME_TICKS     = 6,
  parameter int COLOR_W         = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         col,
  input  logic [8:0]         row,
  input  logic [9:0]         posx,
  input  logic [8:0]         posy,
  input  logic               mode,
  input  logic               anim_en,
  input  logic               frame_tick,
  input  logic               restart,
`ifdef SPRITE_HFLIP_EN
  input  logic               flip,
`endif
  output logic [COLOR_W-1:0] color,
  output logic               opaque,
  output logic [2:0]         frame_idx
);

  localparam int AW = addr_w(FALL_W, SPR_H);
  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  localparam logic [COLOR_W-1:0] TRANSP    = COLOR_W'(TRANSPARENT);
  localparam logic [10:0]        ROLL_W11  = 11'(ROLL_W);
  localparam logic [10:0]        FALL_W11  = 11'(FALL_W);
  localparam logic [9:0]         SPR_H10   = 10'(SPR_H);
  localparam logic [2:0]         ROLL_LAST = 3'(NUM_ROLL_FRAMES - 1);
  localparam logic [2:0]         FALL_LAST = 3'(NUM_FALL_FRAMES - 1);
  localparam logic [TW-1:0]      TICK_LAST = TW'(FRAME_TICKS - 1);

  state_t        state_q, state_n;
  logic [2:0]    frame_q, frame_n;
  logic [TW-1:0] tick_q, tick_n;
  logic [2:0]    frame_last;

  logic          flip_p0;
  logic [10:0]   w_cur_p0;
  logic [10:0]   col_end_p0;
  logic [9:0]    row_end_p0;
  logic          hit_p0;
  logic [9:0]    col_off_p0;
  logic [8:0]    row_off_p0;
  logic [10:0]   x_off_p0;
  logic [AW-1:0] addr_p0;

  logic          hit_p1;
  logic [2:0]    frame_p1;
  state_t        state_p1;
  logic [COLOR_W-1:0] roll_q_p1 [NUM_ROLL_FRAMES];
  logic [COLOR_W-1:0] fall_q_p1 [NUM_FALL_FRAMES];
  logic [COLOR_W-1:0] rom_sel_p1;

`ifdef SPRITE_HFLIP_EN
  assign flip_p0 = flip;
`else
  assign flip_p0 = 1'b0;
`endif

  assign frame_idx  = frame_q;
  assign frame_last = (state_q == FALL) ? FALL_LAST : ROLL_LAST;

  // Sequencer state register: mode state, frame index and tick counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ROLL;
      frame_q <= 3'd0;
      tick_q  <= '0;
    end else begin
      state_q <= state_n;
      frame_q <= frame_n;
      tick_q  <= tick_n;
    end
  end

  // Next-state logic: restart beats a mode change, which beats a frame tick.
  always_comb begin
    state_n = state_q;
    frame_n = frame_q;
    tick_n  = tick_q;
    if (restart) begin
      frame_n = 3'd0;
      tick_n  = '0;
    end else if (state_t'(mode) != state_q) begin
      state_n = state_t'(mode);
      frame_n = 3'd0;
      tick_n  = '0;
    end else if (frame_tick && anim_en) begin
      if (tick_q == TICK_LAST) begin
        tick_n  = '0;
        frame_n = (frame_q == frame_last) ? 3'd0 : frame_q + 3'd1;
      end else begin
        tick_n = tick_q + TW'(1);
      end
    end
  end

  // ---- stage 0: hit test and address generation (combinational) ----
  assign w_cur_p0   = (state_q == FALL) ? FALL_W11 : ROLL_W11;
  assign col_end_p0 = {1'b0, posx} + w_cur_p0;
  assign row_end_p0 = {1'b0, posy} + SPR_H10;
  assign hit_p0     = (col >= posx) && ({1'b0, col} < col_end_p0) &&
                      (row >= posy) && ({1'b0, row} < row_end_p0);
  assign col_off_p0 = col - posx;
  assign row_off_p0 = row - posy;
  assign x_off_p0   = flip_p0 ? (w_cur_p0 - 11'd1 - {1'b0, col_off_p0})
                              : {1'b0, col_off_p0};
  assign addr_p0    = AW'(row_off_p0) * AW'(w_cur_p0) + AW'(x_off_p0);

  // ---- stage 1: ROM read, with hit/frame/state captured alongside ----
  for (genvar gi = 0; gi < NUM_ROLL_FRAMES; gi++) begin : g_roll
    sprite_rom #(
      .DEPTH  (ROLL_W * SPR_H),
      .COLOR_W(COLOR_W),
      .AW     (AW),
      .SEED   (1 + gi)
    ) u_rom (
      .clk (clk),
      .addr(addr_p0),
      .data(roll_q_p1[gi])
    );
  end

  for (genvar gi = 0; gi < NUM_FALL_FRAMES; gi++) begin : g_fall
    sprite_rom #(
      .DEPTH  (FALL_W * SPR_H),
      .COLOR_W(COLOR_W),
      .AW     (AW),
      .SEED   (9 + gi)
    ) u_rom (
      .clk (clk),
      .addr(addr_p0),
      .data(fall_q_p1[gi])
    );
  end

  // Per-pixel control travelling with the ROM read; cleared on reset so the
  // first outputs after release are transparent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_p1   <= 1'b0;
      frame_p1 <= 3'd0;
      state_p1 <= ROLL;
    end else begin
      hit_p1   <= hit_p0;
      frame_p1 <= frame_q;
      state_p1 <= state_q;
    end
  end

  // Pick the frame image that was current when this pixel entered stage 1.
  always_comb begin
    rom_sel_p1 = TRANSP;
    for (int i = 0; i < NUM_ROLL_FRAMES; i++) begin
      if ((state_p1 == ROLL) && (frame_p1 == 3'(i))) rom_sel_p1 = roll_q_p1[i];
    end
    for (int i = 0; i < NUM_FALL_FRAMES; i++) begin
      if ((state_p1 == FALL) && (frame_p1 == 3'(i))) rom_sel_p1 = fall_q_p1[i];
    end
  end

  // ---- stage 2: output register, key colour means not opaque ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color  <= TRANSP;
      opaque <= 1'b0;
    end else begin
      color  <= hit_p1 ? rom_sel_p1 : TRANSP;
      opaque <= hit_p1 && (rom_sel_p1 != TRANSP);
    end
  end

endmodule

// File: tb/tb_sprite_anim_color.sv
// Bench for sprite_anim_color: scoreboard of expected pixels checked by a
// monitor two clocks after issue, plus direct sequencer checks.
// Define SPRITE_HFLIP_EN to also exercise the mirrored image path.
module tb_sprite_anim_color;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  col;
  logic [8:0]  row;
  logic [9:0]  posx;
  logic [8:0]  posy;
  logic        mode;
  logic        anim_en;
  logic        frame_tick;
  logic        restart;
  logic        flip;
  logic [15:0] color;
  logic        opaque;
  logic [2:0]  frame_idx;

  always #5 clk = ~clk;

  sprite_anim_color dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .row       (row),
    .posx      (posx),
    .posy      (posy),
    .mode      (mode),
    .anim_en   (anim_en),
    .frame_tick(frame_tick),
    .restart   (restart),
`ifdef SPRITE_HFLIP_EN
    .flip      (flip),
`endif
    .color     (color),
    .opaque    (opaque),
    .frame_idx (frame_idx)
  );

  typedef struct {
    int          due;
    logic [15:0] c;
    logic        o;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   px_m     = 0;
  int   py_m     = 0;
  bit   flip_m   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent pixel model: {opaque, colour}.
  function automatic logic [16:0] model_pix(int c, int r, bit fall, int frame);
    int w, xo, a, seed;
    w = fall ? 42 : 32;
    if (!(c >= px_m && c < px_m + w && r >= py_m && r < py_m + 24)) return {1'b0, 16'hFFFF};
    xo   = flip_m ? (w - 1 - (c - px_m)) : (c - px_m);
    a    = (r - py_m) * w + xo;
    seed = fall ? 9 + frame : 1 + frame;
    if ((a % 64) == 63) return {1'b0, 16'hFFFF};
    return {1'b1, seed[3:0], 2'b00, a[9:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic pix(int c, int r, bit fall, int frame, int id);
    logic [16:0] m;
    exp_t e;
    col   = 10'(c);
    row   = 9'(r);
    m     = model_pix(c, r, fall, frame);
    e.due = cyc + 2;
    e.c   = m[15:0];
    e.o   = m[16];
    e.id  = id;
    exp_q.push_back(e);
    step();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    col = 10'd0;
    row = 9'd0;
    while (exp_q.size() > 0 && k < 20) begin
      step();
      k++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d pixels never checked, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: compare every expected pixel when its output cycle arrives.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (mon_e.due != cyc || color !== mon_e.c || opaque !== mon_e.o) begin
        n_fail++;
        $display("FAIL pixel id=%0d: color=%h opaque=%b, expected color=%h opaque=%b (due %0d now %0d)",
                 mon_e.id, color, opaque, mon_e.c, mon_e.o, mon_e.due, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cols3 [6];
    rst_n = 1'b0; col = 10'd0; row = 9'd0; posx = 10'd0; posy = 9'd0;
    mode = 1'b0; anim_en = 1'b0; frame_tick = 1'b0; restart = 1'b0; flip = 1'b0;
    step(); step(); step();
    chk("reset color", 32'(color), 32'hFFFF);
    chk("reset opaque", 32'(opaque), 32'd0);
    chk("reset frame_idx", 32'(frame_idx), 32'd0);
    rst_n = 1'b1;
    step();

    // Roll hit window and latency
    px_m = 100; py_m = 50; posx = 10'd100; posy = 9'd50;
    for (int c = 99; c <= 132; c++) pix(c, 50, 1'b0, 0, 1000 + c);
    pix(131, 51, 1'b0, 0, 1200);
    pix(100, 73, 1'b0, 0, 1201);
    pix(100, 74, 1'b0, 0, 1202);
    pix(100, 49, 1'b0, 0, 1203);
    drain();

    // Frame timer, wrap and freeze
    anim_en = 1'b1;
    chk("t2 start", 32'(frame_idx), 32'd0);
    ticks(5);  chk("t2 5 ticks", 32'(frame_idx), 32'd0);
    ticks(1);  chk("t2 6 ticks", 32'(frame_idx), 32'd1);
    ticks(18); chk("t2 24 ticks wrap", 32'(frame_idx), 32'd0);
    ticks(6);  chk("t2 30 ticks", 32'(frame_idx), 32'd1);
    anim_en = 1'b0;
    ticks(12); chk("t2 frozen", 32'(frame_idx), 32'd1);
    anim_en = 1'b1;
    ticks(12); chk("t2 frame 3", 32'(frame_idx), 32'd3);
    pix(100, 51, 1'b0, 3, 2000);
    drain();

    // Mode change to fall
    mode = 1'b1;
    step();
    chk("t3 mode change frame", 32'(frame_idx), 32'd0);
    cols3 = '{99, 100, 131, 132, 141, 142};
    foreach (cols3[i]) pix(cols3[i], 50, 1'b1, 0, 3000 + cols3[i]);
    pix(121, 51, 1'b1, 0, 3200);
    drain();
    ticks(6);  chk("t3 fall frame 1", 32'(frame_idx), 32'd1);
    pix(105, 52, 1'b1, 1, 3300);
    drain();
    ticks(6);  chk("t3 fall wrap", 32'(frame_idx), 32'd0);

    // Restart and mode change priority over the final tick
    ticks(5);
    frame_tick = 1'b1; restart = 1'b1;
    step();
    frame_tick = 1'b0; restart = 1'b0;
    chk("t4 restart+tick", 32'(frame_idx), 32'd0);
    ticks(5);  chk("t4 tick_cnt cleared", 32'(frame_idx), 32'd0);
    ticks(1);  chk("t4 advance", 32'(frame_idx), 32'd1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("t4 restart", 32'(frame_idx), 32'd0);
    ticks(5);
    mode = 1'b0; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("t4 mode+tick", 32'(frame_idx), 32'd0);
    ticks(5);  chk("t4 roll tick_cnt cleared", 32'(frame_idx), 32'd0);
    ticks(1);  chk("t4 roll advance", 32'(frame_idx), 32'd1);
    restart = 1'b1;
    step();
    restart = 1'b0;

    // Right-edge position, no wrap-around hits
    px_m = 1010; posx = 10'd1010;
    for (int c = 0; c <= 20; c++) pix(c, 50, 1'b0, 0, 5000 + c);
    pix(1010, 50, 1'b0, 0, 5100);
    pix(1023, 50, 1'b0, 0, 5101);
    pix(1023, 52, 1'b0, 0, 5102);
    drain();

`ifdef SPRITE_HFLIP_EN
    px_m = 100; posx = 10'd100;
    flip = 1'b1; flip_m = 1'b1;
    pix(100, 50, 1'b0, 0, 6000);
    pix(131, 50, 1'b0, 0, 6001);
    pix(100, 51, 1'b0, 0, 6002);
    drain();
    flip = 1'b0; flip_m = 1'b0;
`endif

    // Reset mid-line
    px_m = 100; posx = 10'd100;
    ticks(6); chk("t6 frame before reset", 32'(frame_idx), 32'd1);
    col = 10'd110; row = 9'd50;
    step(); step();
    chk("t6 pixel before reset", 32'(color), 32'h200A);
    rst_n = 1'b0;
    #1;
    chk("t6 async color", 32'(color), 32'hFFFF);
    chk("t6 async opaque", 32'(opaque), 32'd0);
    chk("t6 async frame_idx", 32'(frame_idx), 32'd0);
    step(); step();
    rst_n = 1'b1;
    chk("t6 release color", 32'(color), 32'hFFFF);
    step();
    chk("t6 first edge color", 32'(color), 32'hFFFF);
    chk("t6 first edge opaque", 32'(opaque), 32'd0);
    step();
    chk("t6 second edge color", 32'(color), 32'h100A);
    chk("t6 second edge opaque", 32'(opaque), 32'd1);
    col = 10'd0; row = 9'd0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
